block_schedule_dispatcher: RTL and testbench

Downstream stage of the inter-layer block scheduler. It accepts one finalised block-pair schedule: the schedule type, plus start layer and layer count for block0 and block1. It then issues per-layer compute commands to the NPU and in-pipeline CIM engines in parallel, one outstanding command per engine. When both blocks have completed it pulses schedule_done_o, which acts as the scheduler's schedule-finish indication.

---
 rtl/block_schedule_dispatcher_pkg.sv | 20 ++
 rtl/block_schedule_dispatcher_channel.sv | 74 +++++++
 rtl/block_schedule_dispatcher.sv | 120 ++++++++++++
 tb/tb_block_schedule_dispatcher.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/block_schedule_dispatcher_pkg.sv
// Shared constants for the block-pair schedule dispatcher:
// schedule types, channel and top FSM encodings.
package block_schedule_dispatcher_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic BLOCK0_CIM_BLOCK1_NPU = 1'b0;
  localparam logic BLOCK0_NPU_BLOCK1_CIM = 1'b1;

  localparam logic [1:0] C_IDLE  = 2'd0;
  localparam logic [1:0] C_ISSUE = 2'd1;
  localparam logic [1:0] C_WAIT  = 2'd2;
  localparam logic [1:0] C_FIN   = 2'd3;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/block_schedule_dispatcher_channel.sv
// One engine channel: walks a block's layers, one command
// outstanding at a time, and reports when the block is finished.
module block_schedule_dispatcher_channel
  import block_schedule_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [ADDR_W-1:0] start_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              cmd_valid_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  input  logic              cmd_ready_i,
  input  logic              done_i,
  output logic              fin_o,
  output logic              spurious_o
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    addr_d  = addr_q;
    unique case (state_q)
      C_IDLE: begin
        if (load_i) begin
          rem_d   = count_i;
          addr_d  = start_i;
          state_d = (count_i == '0) ? C_FIN : C_ISSUE;
        end
      end
      C_ISSUE: begin
        if (cmd_ready_i) state_d = C_WAIT;
      end
      C_WAIT: begin
        if (done_i) begin
          rem_d   = rem_q - CNT_W'(1);
          addr_d  = addr_q + ADDR_W'(1);
          state_d = (rem_q == CNT_W'(1)) ? C_FIN : C_ISSUE;
        end
      end
      C_FIN: begin
        if (clear_i) state_d = C_IDLE;
      end
      default: state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= C_IDLE;
      rem_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
    end
  end

  assign cmd_valid_o = (state_q == C_ISSUE);
  assign cmd_addr_o  = addr_q;
  assign fin_o       = (state_q == C_FIN);
  // a done while issuing (incl. the handshake cycle) is never ours
  assign spurious_o  = done_i && (state_q != C_WAIT);

endmodule

// File: rtl/block_schedule_dispatcher.sv
// Accepts a block-pair schedule, maps blocks onto NPU/CIM
// channels and pulses schedule_done_o once both are finished.
module block_schedule_dispatcher
  import block_schedule_dispatcher_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              schedule_valid_i,
  output logic              schedule_ready_o,
  input  logic              schedule_type_i,
  input  logic [ADDR_W-1:0] block0_start_i,
  input  logic [CNT_W-1:0]  block0_count_i,
  input  logic [ADDR_W-1:0] block1_start_i,
  input  logic [CNT_W-1:0]  block1_count_i,
  output logic              npu_cmd_valid_o,
  output logic [ADDR_W-1:0] npu_cmd_addr_o,
  output logic              npu_cmd_block_o,
  input  logic              npu_cmd_ready_i,
  input  logic              npu_done_i,
  output logic              cim_cmd_valid_o,
  output logic [ADDR_W-1:0] cim_cmd_addr_o,
  output logic              cim_cmd_block_o,
  input  logic              cim_cmd_ready_i,
  input  logic              cim_done_i,
  output logic              schedule_done_o,
  output logic              busy_o,
  output logic              spurious_done_o
);

  logic [1:0]        state_q, state_d;
  logic              type_q;
  logic              spur_q;
  logic              accept, clear, npu_b0;
  logic              npu_fin, cim_fin;
  logic              npu_spur, cim_spur;
  logic [ADDR_W-1:0] npu_start, cim_start;
  logic [CNT_W-1:0]  npu_count, cim_count;

  assign accept = schedule_valid_i && (state_q == S_IDLE);
  assign clear  = (state_q == S_DONE);

  // channels load straight from the inputs on the accept edge
  assign npu_b0    = (schedule_type_i == BLOCK0_NPU_BLOCK1_CIM);
  assign npu_start = npu_b0 ? block0_start_i : block1_start_i;
  assign npu_count = npu_b0 ? block0_count_i : block1_count_i;
  assign cim_start = npu_b0 ? block1_start_i : block0_start_i;
  assign cim_count = npu_b0 ? block1_count_i : block0_count_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_RUN;
      S_RUN:   if (npu_fin && cim_fin) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      type_q  <= 1'b0;
      spur_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      spur_q  <= spur_q | npu_spur | cim_spur;
      if (accept) type_q <= schedule_type_i;
    end
  end

  block_schedule_dispatcher_channel #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_npu (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .clear_i    (clear),
    .start_i    (npu_start),
    .count_i    (npu_count),
    .cmd_valid_o(npu_cmd_valid_o),
    .cmd_addr_o (npu_cmd_addr_o),
    .cmd_ready_i(npu_cmd_ready_i),
    .done_i     (npu_done_i),
    .fin_o      (npu_fin),
    .spurious_o (npu_spur)
  );

  block_schedule_dispatcher_channel #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) u_cim (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (accept),
    .clear_i    (clear),
    .start_i    (cim_start),
    .count_i    (cim_count),
    .cmd_valid_o(cim_cmd_valid_o),
    .cmd_addr_o (cim_cmd_addr_o),
    .cmd_ready_i(cim_cmd_ready_i),
    .done_i     (cim_done_i),
    .fin_o      (cim_fin),
    .spurious_o (cim_spur)
  );

  assign npu_cmd_block_o =
    npu_cmd_valid_o && (type_q == BLOCK0_CIM_BLOCK1_NPU);
  assign cim_cmd_block_o =
    cim_cmd_valid_o && (type_q == BLOCK0_NPU_BLOCK1_CIM);

  assign schedule_ready_o = (state_q == S_IDLE);
  assign busy_o           = (state_q == S_RUN);
  assign schedule_done_o  = (state_q == S_DONE);
  assign spurious_done_o  = spur_q;

endmodule

// File: tb/tb_block_schedule_dispatcher.sv
// Self-checking bench: engine models plus a schedule-level
// reference model of commands, done timing and flags.
module tb_block_schedule_dispatcher;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        schedule_valid_i = 1'b0;
  logic        schedule_ready_o;
  logic        schedule_type_i = 1'b0;
  logic [31:0] block0_start_i = '0;
  logic [15:0] block0_count_i = '0;
  logic [31:0] block1_start_i = '0;
  logic [15:0] block1_count_i = '0;
  logic        npu_cmd_valid_o;
  logic [31:0] npu_cmd_addr_o;
  logic        npu_cmd_block_o;
  logic        npu_cmd_ready_i = 1'b0;
  logic        npu_done_i = 1'b0;
  logic        cim_cmd_valid_o;
  logic [31:0] cim_cmd_addr_o;
  logic        cim_cmd_block_o;
  logic        cim_cmd_ready_i = 1'b0;
  logic        cim_done_i = 1'b0;
  logic        schedule_done_o;
  logic        busy_o;
  logic        spurious_done_o;

  always #5 clk_i = ~clk_i;

  block_schedule_dispatcher #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .schedule_valid_i(schedule_valid_i),
    .schedule_ready_o(schedule_ready_o),
    .schedule_type_i (schedule_type_i),
    .block0_start_i  (block0_start_i),
    .block0_count_i  (block0_count_i),
    .block1_start_i  (block1_start_i),
    .block1_count_i  (block1_count_i),
    .npu_cmd_valid_o (npu_cmd_valid_o),
    .npu_cmd_addr_o  (npu_cmd_addr_o),
    .npu_cmd_block_o (npu_cmd_block_o),
    .npu_cmd_ready_i (npu_cmd_ready_i),
    .npu_done_i      (npu_done_i),
    .cim_cmd_valid_o (cim_cmd_valid_o),
    .cim_cmd_addr_o  (cim_cmd_addr_o),
    .cim_cmd_block_o (cim_cmd_block_o),
    .cim_cmd_ready_i (cim_cmd_ready_i),
    .cim_done_i      (cim_done_i),
    .schedule_done_o (schedule_done_o),
    .busy_o          (busy_o),
    .spurious_done_o (spurious_done_o)
  );

  typedef struct packed {
    logic [31:0] a;
    logic        b;
  } cmd_t;

  localparam int INF = 1 << 30;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // reference model state (engine 0 = NPU, 1 = CIM)
  cmd_t        q_npu[$];
  cmd_t        q_cim[$];
  logic [31:0] log_npu[$];
  logic [31:0] log_cim[$];
  logic        logb_npu[$];
  logic        logb_cim[$];
  int          rem[2];
  int          outst[2];
  int          cnt[2];
  int          force_lo[2];
  bit          stall[2];
  logic [31:0] stall_a[2];
  bit          inj[2];
  bit          active = 0;
  int          exp_done = INF;
  bit          spur_m = 0;
  bit          got_acc = 0;
  int          rdy_pct = 100;
  int          dly_min = 3;
  int          dly_max = 3;
  int          acc_cyc = 0;
  int          done_cyc = 0;
  int          done_pulses = 0;

  logic        nxt_valid = 0;
  logic        nxt_type = 0;
  logic [31:0] nxt_s0 = '0;
  logic [31:0] nxt_s1 = '0;
  logic [15:0] nxt_c0 = '0;
  logic [15:0] nxt_c1 = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    q_npu.delete();
    q_cim.delete();
    for (int e = 0; e < 2; e++) begin
      rem[e] = 0; outst[e] = 0; cnt[e] = 0; force_lo[e] = 0;
      stall[e] = 0; stall_a[e] = '0; inj[e] = 0;
    end
    active = 0;
    exp_done = INF;
    spur_m = 0;
  endtask

  task automatic clear_logs();
    log_npu.delete(); log_cim.delete();
    logb_npu.delete(); logb_cim.delete();
  endtask

  task automatic engine(input int e);
    logic v, b, r, d;
    logic [31:0] a;
    cmd_t c;
    bit empty;
    v = (e == 0) ? npu_cmd_valid_o : cim_cmd_valid_o;
    a = (e == 0) ? npu_cmd_addr_o : cim_cmd_addr_o;
    b = (e == 0) ? npu_cmd_block_o : cim_cmd_block_o;
    if (stall[e]) begin
      chk(e == 0 ? "npu_hold_valid" : "cim_hold_valid", 64'(v), 64'd1);
      chk(e == 0 ? "npu_hold_addr" : "cim_hold_addr", 64'(a),
          64'(stall_a[e]));
    end
    d = 1'b0;
    if (outst[e] != 0) begin
      cnt[e]--;
      if (cnt[e] == 0) begin
        d = 1'b1;
        outst[e] = 0;
        rem[e]--;
      end
    end else if (inj[e]) begin
      d = 1'b1;
      spur_m = 1;
    end
    inj[e] = 0;
    if (force_lo[e] > 0) begin
      r = 1'b0;
      force_lo[e]--;
    end else begin
      r = ($urandom_range(0, 99) < rdy_pct);
    end
    if (v && r) begin
      empty = (e == 0) ? (q_npu.size() == 0) : (q_cim.size() == 0);
      if (empty) begin
        chk(e == 0 ? "npu_unexpected_cmd" : "cim_unexpected_cmd",
            64'(v), 64'd0);
      end else begin
        if (e == 0) c = q_npu.pop_front();
        else c = q_cim.pop_front();
        chk(e == 0 ? "npu_addr" : "cim_addr", 64'(a), 64'(c.a));
        chk(e == 0 ? "npu_block" : "cim_block", 64'(b), 64'(c.b));
      end
      if (e == 0) begin log_npu.push_back(a); logb_npu.push_back(b); end
      else begin log_cim.push_back(a); logb_cim.push_back(b); end
      outst[e] = 1;
      cnt[e] = $urandom_range(dly_min, dly_max);
    end
    stall[e] = v && !r;
    stall_a[e] = a;
    if (e == 0) begin
      npu_cmd_ready_i = r; npu_done_i = d;
    end else begin
      cim_cmd_ready_i = r; cim_done_i = d;
    end
  endtask

  task automatic accept();
    bit t;
    t = nxt_type;
    got_acc = 1;
    acc_cyc = cyc;
    active = 1;
    exp_done = INF;
    for (int i = 0; i < int'(nxt_c0); i++) begin
      if (t) q_npu.push_back('{a: nxt_s0 + 32'(i), b: 1'b0});
      else q_cim.push_back('{a: nxt_s0 + 32'(i), b: 1'b0});
    end
    for (int i = 0; i < int'(nxt_c1); i++) begin
      if (t) q_cim.push_back('{a: nxt_s1 + 32'(i), b: 1'b1});
      else q_npu.push_back('{a: nxt_s1 + 32'(i), b: 1'b1});
    end
    rem[0] = t ? int'(nxt_c0) : int'(nxt_c1);
    rem[1] = t ? int'(nxt_c1) : int'(nxt_c0);
  endtask

  task automatic cycle();
    bit rdy_m;
    @(negedge clk_i);
    cyc++;
    rdy_m = !active;
    chk("ready", 64'(schedule_ready_o), 64'(rdy_m));
    chk("busy", 64'(busy_o), 64'(active && cyc < exp_done));
    chk("sched_done", 64'(schedule_done_o),
        64'(active && cyc == exp_done));
    chk("spurious", 64'(spurious_done_o), 64'(spur_m));
    if (schedule_done_o) begin
      done_cyc = cyc;
      done_pulses++;
    end
    if (active && cyc == exp_done) active = 0;
    engine(0);
    engine(1);
    if (nxt_valid && rdy_m) accept();
    if (active && exp_done == INF && rem[0] == 0 && rem[1] == 0)
      exp_done = cyc + 2;
    schedule_valid_i = nxt_valid;
    schedule_type_i  = nxt_type;
    block0_start_i   = nxt_s0;
    block0_count_i   = nxt_c0;
    block1_start_i   = nxt_s1;
    block1_count_i   = nxt_c1;
  endtask

  task automatic offer(input logic t, input logic [31:0] s0,
                       input logic [15:0] c0, input logic [31:0] s1,
                       input logic [15:0] c1, input bit keep);
    int k;
    nxt_type = t; nxt_s0 = s0; nxt_c0 = c0; nxt_s1 = s1; nxt_c1 = c1;
    nxt_valid = 1;
    got_acc = 0;
    k = 0;
    while (!got_acc && k < 500) begin
      cycle();
      k++;
    end
    if (!got_acc) chk("accept_timeout", 64'd0, 64'd1);
    if (!keep) nxt_valid = 0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (active && k < 1000) begin
      cycle();
      k++;
    end
    if (active) chk("done_timeout", 64'd0, 64'd1);
    cycle();
  endtask

  task automatic do_reset();
    #2;
    rst_ni = 1'b0;
    #1;
    chk("rst_npu_valid", 64'(npu_cmd_valid_o), 64'd0);
    chk("rst_cim_valid", 64'(cim_cmd_valid_o), 64'd0);
    chk("rst_ready", 64'(schedule_ready_o), 64'd1);
    chk("rst_done", 64'(schedule_done_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_spurious", 64'(spurious_done_o), 64'd0);
    model_clear();
    nxt_valid = 0;
    schedule_valid_i = 0;
    npu_cmd_ready_i = 0; npu_done_i = 0;
    cim_cmd_ready_i = 0; cim_done_i = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    int k;
    int a1;
    logic [31:0] s0, s1;
    model_clear();
    #1;
    do_reset();

    // directed: type 0, CIM 4..5, NPU 10..12, ready 1, done +3
    clear_logs();
    rdy_pct = 100; dly_min = 3; dly_max = 3;
    offer(1'b0, 32'd4, 16'd2, 32'd10, 16'd3, 0);
    wait_idle();
    chk("t1_cim_n", 64'(log_cim.size()), 64'd2);
    chk("t1_npu_n", 64'(log_npu.size()), 64'd3);
    if (log_cim.size() == 2 && log_npu.size() == 3) begin
      chk("t1_cim0", 64'(log_cim[0]), 64'd4);
      chk("t1_cim1", 64'(log_cim[1]), 64'd5);
      chk("t1_cimb", 64'(logb_cim[0] | logb_cim[1]), 64'd0);
      chk("t1_npu0", 64'(log_npu[0]), 64'd10);
      chk("t1_npu2", 64'(log_npu[2]), 64'd12);
      chk("t1_npub", 64'(logb_npu[0] & logb_npu[2]), 64'd1);
    end
    chk("t1_latency", 64'(done_cyc - acc_cyc), 64'd14);

    // type 1, both counts zero
    clear_logs();
    offer(1'b1, 32'd77, 16'd0, 32'd88, 16'd0, 0);
    wait_idle();
    chk("t2_latency", 64'(done_cyc - acc_cyc), 64'd2);
    chk("t2_no_cmds", 64'(log_npu.size() + log_cim.size()), 64'd0);

    // type 1, NPU stalled 5 cycles while CIM proceeds
    clear_logs();
    dly_min = 2; dly_max = 2;
    offer(1'b1, 32'd100, 16'd2, 32'd200, 16'd2, 0);
    force_lo[0] = 5;
    repeat (5) cycle();
    chk("t3_npu_valid", 64'(npu_cmd_valid_o), 64'd1);
    chk("t3_npu_addr", 64'(npu_cmd_addr_o), 64'd100);
    chk("t3_cim_progress", 64'(log_cim.size()), 64'd2);
    chk("t3_npu_none", 64'(log_npu.size()), 64'd0);
    wait_idle();

    // spurious CIM done while idle, then a normal schedule
    inj[1] = 1;
    cycle();
    cycle();
    chk("t4_spur_set", 64'(spurious_done_o), 64'd1);
    clear_logs();
    offer(1'b0, 32'd7, 16'd1, 32'd8, 16'd1, 0);
    wait_idle();
    chk("t4_cim", 64'(log_cim.size() == 1 && log_cim[0] == 7), 64'd1);
    chk("t4_npu", 64'(log_npu.size() == 1 && log_npu[0] == 8), 64'd1);
    chk("t4_spur_stays", 64'(spurious_done_o), 64'd1);

    // reset in the middle of a run, after one NPU layer
    dly_min = 3; dly_max = 3;
    done_pulses = 0;
    offer(1'b0, 32'd50, 16'd3, 32'd60, 16'd3, 0);
    k = 0;
    while (rem[0] != 2 && k < 100) begin
      cycle();
      k++;
    end
    chk("t5_progress", 64'(rem[0]), 64'd2);
    do_reset();
    repeat (10) cycle();
    chk("t5_no_done", 64'(done_pulses), 64'd0);

    // back-to-back: valid held through the first schedule
    done_pulses = 0;
    offer(1'b0, 32'd20, 16'd1, 32'd30, 16'd1, 1);
    a1 = acc_cyc;
    offer(1'b1, 32'd40, 16'd1, 32'd50, 16'd1, 0);
    chk("t6_second_acc", 64'(acc_cyc - done_cyc), 64'd1);
    chk("t6_first_done", 64'(done_pulses), 64'd1);
    chk("t6_gap", 64'(acc_cyc - a1 > 2), 64'd1);
    wait_idle();
    chk("t6_done_total", 64'(done_pulses), 64'd2);

    // randomized schedules, with occasional address wrap
    dly_min = 1; dly_max = 4;
    for (int n = 0; n < 40; n++) begin
      rdy_pct = $urandom_range(30, 100);
      s0 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : $urandom();
      s1 = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom();
      offer(1'($urandom_range(0, 1)), s0, 16'($urandom_range(0, 4)),
            s1, 16'($urandom_range(0, 4)), ($urandom_range(0, 2) == 0));
      if (!nxt_valid) begin
        repeat ($urandom_range(0, 3)) cycle();
      end
    end
    nxt_valid = 0;
    wait_idle();
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
